// File: rtl/cavlc_coeff_expander_if.sv
// Handshake and data bundle between the CAVLC parser, the coefficient expander
// and the inverse-quant stage.
interface cavlc_coeff_expander_if #(
    parameter int COEFF_W = 8
);
    logic                      blk_start_i;
    logic [4:0]                total_coeff_i;
    logic [4:0]                total_zeros_i;
    logic [4:0]                max_coeff_i;
    logic                      pair_valid_i;
    logic                      pair_ready_o;
    logic signed [COEFF_W-1:0] level_i;
    logic [3:0]                run_i;
    logic                      coeff_valid_o;
    logic                      coeff_ready_i;
    logic signed [COEFF_W-1:0] coeff_o;
    logic [3:0]                coeff_idx_o;
    logic                      blk_done_o;
    logic                      busy_o;
    logic                      err_o;

    modport master (
        output blk_start_i, total_coeff_i, total_zeros_i, max_coeff_i,
        output pair_valid_i, level_i, run_i, coeff_ready_i,
        input  pair_ready_o, coeff_valid_o, coeff_o, coeff_idx_o,
        input  blk_done_o, busy_o, err_o
    );

    modport slave (
        input  blk_start_i, total_coeff_i, total_zeros_i, max_coeff_i,
        input  pair_valid_i, level_i, run_i, coeff_ready_i,
        output pair_ready_o, coeff_valid_o, coeff_o, coeff_idx_o,
        output blk_done_o, busy_o, err_o
    );
endinterface

// File: rtl/cavlc_coeff_expander.sv
// Rebuilds a CAVLC block's coefficient array from (level, run_before) pairs and
// streams it out in ascending zig-zag order.
//
// state | meaning
// IDLE  | waiting for blk_start_i
// LOAD  | accepting level/run pairs, highest frequency first
// EMIT  | streaming buf[0..max_coeff-1]
// DONE  | one-cycle blk_done_o pulse
module cavlc_coeff_expander #(
    parameter int COEFF_W   = 8,
    parameter int MAX_COEFF = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic h264_reset,
    cavlc_coeff_expander_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                r_state;
    logic signed [COEFF_W-1:0] r_buf [MAX_COEFF];
    logic [4:0]                r_remain;
    logic [4:0]                r_zeros;
    logic [4:0]                r_pos;
    logic [4:0]                r_max;
    logic [3:0]                r_k;
    logic                      r_err;

    logic [5:0] w_sum;
    logic       w_max_ok;
    logic       w_bad;
    logic [4:0] w_run;
    logic       w_over;
    logic [4:0] w_r;
    logic       w_pair_hs;
    logic       w_last;

    assign w_sum    = {1'b0, bus.total_coeff_i} + {1'b0, bus.total_zeros_i};
    // An unusable block size is flagged and emitted as a full-size zero block.
    assign w_max_ok = (bus.max_coeff_i != 5'd0) && (bus.max_coeff_i <= 5'(MAX_COEFF));
    assign w_bad    = (w_sum > {1'b0, bus.max_coeff_i})
                    || (bus.total_coeff_i > bus.max_coeff_i) || !w_max_ok;

    assign w_run     = {1'b0, bus.run_i};
    assign w_over    = w_run > r_zeros;
    assign w_r       = w_over ? r_zeros : w_run;
    assign w_pair_hs = bus.pair_ready_o && bus.pair_valid_i;
    assign w_last    = ({1'b0, r_k} == (r_max - 5'd1));

    assign bus.pair_ready_o  = (r_state == LOAD) && !h264_reset;
    assign bus.coeff_valid_o = (r_state == EMIT);
    assign bus.coeff_o       = (r_state == EMIT) ? r_buf[r_k] : '0;
    assign bus.coeff_idx_o   = (r_state == EMIT) ? r_k : 4'd0;
    assign bus.blk_done_o    = (r_state == DONE);
    assign bus.busy_o        = (r_state != IDLE);
    assign bus.err_o         = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_remain <= 5'd0;
            r_zeros  <= 5'd0;
            r_pos    <= 5'd0;
            r_max    <= 5'(MAX_COEFF);
            r_k      <= 4'd0;
            r_err    <= 1'b0;
            for (int i = 0; i < MAX_COEFF; i++) r_buf[i] <= '0;
        end else if (h264_reset) begin
            r_state  <= IDLE;
            r_remain <= 5'd0;
            r_zeros  <= 5'd0;
            r_pos    <= 5'd0;
            r_max    <= 5'(MAX_COEFF);
            r_k      <= 4'd0;
            r_err    <= 1'b0;
            for (int i = 0; i < MAX_COEFF; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.blk_start_i) begin
                        for (int i = 0; i < MAX_COEFF; i++) r_buf[i] <= '0;
                        r_err    <= w_bad;
                        r_max    <= w_max_ok ? bus.max_coeff_i : 5'(MAX_COEFF);
                        r_remain <= bus.total_coeff_i;
                        r_zeros  <= bus.total_zeros_i;
                        r_pos    <= w_sum[4:0] - 5'd1;
                        r_k      <= 4'd0;
                        r_state  <= ((bus.total_coeff_i == 5'd0) || w_bad) ? EMIT : LOAD;
                    end
                end
                LOAD: begin
                    if (w_pair_hs) begin
                        r_buf[r_pos[3:0]] <= bus.level_i;
                        r_remain          <= r_remain - 5'd1;
                        if (r_remain > 5'd1) begin
                            // Over-long runs are clamped so pos cannot wrap below 0.
                            r_pos   <= r_pos - w_r - 5'd1;
                            r_zeros <= r_zeros - w_r;
                            if (w_over) r_err <= 1'b1;
                        end else begin
                            r_state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.coeff_ready_i) begin
                        if (w_last) r_state <= DONE;
                        else        r_k     <= r_k + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cavlc_coeff_expander.sv
// Scenario bench for cavlc_coeff_expander: a block model fills a scoreboard
// queue at stimulus time, and output beats are popped and compared.
module tb_cavlc_coeff_expander;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic h264_reset;

    cavlc_coeff_expander_if #(.COEFF_W(CW)) bus ();

    cavlc_coeff_expander #(.COEFF_W(CW), .MAX_COEFF(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .h264_reset (h264_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]           idx;
        logic signed [CW-1:0] val;
    } beat_t;

    beat_t                exp_q[$];
    int                   n_total = 0;
    int                   n_pass  = 0;
    logic signed [CW-1:0] t_lv [16];
    int                   t_rn [16];

    // Reference decode of one block; pushes every expected beat.
    task automatic model_push(input int tc, input int tz, input int mx, output bit e_err);
        logic signed [CW-1:0] m [16];
        int    pos, zl, r;
        beat_t b;
        for (int i = 0; i < 16; i++) m[i] = '0;
        e_err = 1'b0;
        if ((tc + tz > mx) || (tc > mx)) begin
            e_err = 1'b1;
        end else if (tc > 0) begin
            pos = tc + tz - 1;
            zl  = tz;
            for (int i = 0; i < tc; i++) begin
                m[pos] = t_lv[i];
                if (i < tc - 1) begin
                    r = (t_rn[i] > zl) ? zl : t_rn[i];
                    if (t_rn[i] > zl) e_err = 1'b1;
                    pos = pos - r - 1;
                    zl  = zl - r;
                end
            end
        end
        for (int i = 0; i < mx; i++) begin
            b.idx = 4'(i);
            b.val = m[i];
            exp_q.push_back(b);
        end
    endtask

    task automatic start_block(input int tc, input int tz, input int mx);
        @(negedge clk);
        bus.blk_start_i   = 1'b1;
        bus.total_coeff_i = 5'(tc);
        bus.total_zeros_i = 5'(tz);
        bus.max_coeff_i   = 5'(mx);
        @(negedge clk);
        bus.blk_start_i   = 1'b0;
    endtask

    task automatic send_pairs(input int n, input bit gaps);
        int cnt;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 0)) begin
                bus.pair_valid_i = 1'b0;
                @(negedge clk);
            end
            bus.pair_valid_i = 1'b1;
            bus.level_i      = t_lv[i];
            bus.run_i        = 4'(t_rn[i]);
            #1;
            cnt = 0;
            while (!bus.pair_ready_o && cnt < 20) begin
                @(negedge clk);
                #1;
                cnt++;
            end
            n_total++;
            if (!bus.pair_ready_o) $display("FAIL pair_ready pair %0d: ready=%b required 1", i, bus.pair_ready_o);
            else n_pass++;
            @(negedge clk);
        end
        bus.pair_valid_i = 1'b0;
    endtask

    task automatic collect(input bit toggle, input int budget);
        int         cyc = 0;
        bit         rdy = 1'b1;
        bit         stalled = 1'b0;
        logic [3:0] pidx = 4'd0;
        logic [CW-1:0] pval = '0;
        beat_t      e;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            bus.coeff_ready_i = toggle ? rdy : 1'b1;
            rdy = ~rdy;
            #1;
            if (bus.coeff_valid_o) begin
                if (stalled) begin
                    n_total++;
                    if ({bus.coeff_idx_o, bus.coeff_o} !== {pidx, pval})
                        $display("FAIL hold: idx=%0d val=%0d required idx=%0d val=%0d",
                                 bus.coeff_idx_o, bus.coeff_o, pidx, $signed(pval));
                    else n_pass++;
                end
                if (bus.coeff_ready_i) begin
                    e = exp_q.pop_front();
                    n_total++;
                    if ({bus.coeff_idx_o, bus.coeff_o} !== {e.idx, e.val})
                        $display("FAIL beat: idx=%0d val=%0d required idx=%0d val=%0d",
                                 bus.coeff_idx_o, bus.coeff_o, e.idx, e.val);
                    else n_pass++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pidx = bus.coeff_idx_o;
                    pval = bus.coeff_o;
                end
            end
            cyc++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL beat_timeout: %0d beats missing, required 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        bus.coeff_ready_i = 1'b0;
        #1;
        n_total++;
        if ({bus.blk_done_o, bus.coeff_valid_o} !== 2'b10)
            $display("FAIL done_pulse: done=%b valid=%b required done=1 valid=0", bus.blk_done_o, bus.coeff_valid_o);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.blk_done_o, bus.busy_o} !== 2'b00)
            $display("FAIL done_end: done=%b busy=%b required 0 0", bus.blk_done_o, bus.busy_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        h264_reset = 1'b0;
        bus.blk_start_i = 1'b0; bus.total_coeff_i = '0; bus.total_zeros_i = '0; bus.max_coeff_i = '0;
        bus.pair_valid_i = 1'b0; bus.level_i = '0; bus.run_i = '0; bus.coeff_ready_i = 1'b0;
        #1 rst = 1'b0;
        #2;
        n_total++;
        if ({bus.pair_ready_o, bus.coeff_valid_o, bus.coeff_o, bus.coeff_idx_o,
             bus.blk_done_o, bus.busy_o, bus.err_o} !== '0)
            $display("FAIL reset_outputs: busy=%b valid=%b err=%b required all 0", bus.busy_o, bus.coeff_valid_o, bus.err_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero_block();
        bit e;
        model_push(0, 0, 16, e);
        start_block(0, 0, 16);
        #1;
        n_total++;
        if ({bus.coeff_valid_o, bus.pair_ready_o, bus.err_o} !== {2'b10, e})
            $display("FAIL zero_latency: valid=%b ready=%b err=%b required 1 0 %b",
                     bus.coeff_valid_o, bus.pair_ready_o, bus.err_o, e);
        else n_pass++;
        collect(1'b0, 100);
    endtask

    task automatic load_basic();
        t_lv[0] = 8'sd1;  t_rn[0] = 1;
        t_lv[1] = 8'sd1;  t_rn[1] = 0;
        t_lv[2] = -8'sd1; t_rn[2] = 2;
        t_lv[3] = -8'sd1; t_rn[3] = 0;
        t_lv[4] = 8'sd3;  t_rn[4] = 9;
    endtask

    task automatic test_basic();
        bit e;
        load_basic();
        model_push(5, 4, 16, e);
        start_block(5, 4, 16);
        send_pairs(5, 1'b0);
        #1;
        n_total++;
        if ({bus.coeff_valid_o, bus.err_o} !== {1'b1, e})
            $display("FAIL basic_emit: valid=%b err=%b required 1 %b", bus.coeff_valid_o, bus.err_o, e);
        else n_pass++;
        collect(1'b0, 100);
    endtask

    task automatic test_stall();
        bit e;
        load_basic();
        model_push(5, 4, 16, e);
        start_block(5, 4, 16);
        send_pairs(5, 1'b1);
        // A start pulse while busy must be ignored.
        bus.blk_start_i = 1'b1;
        bus.total_coeff_i = 5'd10; bus.total_zeros_i = 5'd10; bus.max_coeff_i = 5'd4;
        @(negedge clk);
        bus.blk_start_i = 1'b0;
        #1;
        n_total++;
        if ({bus.coeff_valid_o, bus.coeff_idx_o, bus.err_o} !== {1'b1, 4'd0, e})
            $display("FAIL busy_start: valid=%b idx=%0d err=%b required 1 0 %b",
                     bus.coeff_valid_o, bus.coeff_idx_o, bus.err_o, e);
        else n_pass++;
        collect(1'b1, 200);
    endtask

    task automatic test_recover(input logic signed [CW-1:0] lv);
        bit e;
        t_lv[0] = lv; t_rn[0] = 5;
        model_push(1, 0, 4, e);
        start_block(1, 0, 4);
        #1;
        n_total++;
        if (bus.err_o !== e) $display("FAIL err_clear: err=%b required %b", bus.err_o, e);
        else n_pass++;
        send_pairs(1, 1'b0);
        collect(1'b0, 50);
    endtask

    task automatic test_overflow();
        bit e;
        model_push(10, 8, 16, e);
        start_block(10, 8, 16);
        #1;
        n_total++;
        if ({bus.err_o, bus.pair_ready_o, bus.coeff_valid_o} !== {e, 2'b01})
            $display("FAIL overflow: err=%b ready=%b valid=%b required %b 0 1",
                     bus.err_o, bus.pair_ready_o, bus.coeff_valid_o, e);
        else n_pass++;
        collect(1'b0, 100);
        test_recover(8'sd2);
    endtask

    task automatic test_clamp();
        bit e;
        t_lv[0] = 8'sd5; t_rn[0] = 3;
        t_lv[1] = 8'sd7; t_rn[1] = 0;
        model_push(2, 1, 15, e);
        start_block(2, 1, 15);
        send_pairs(2, 1'b0);
        #1;
        n_total++;
        if (bus.err_o !== e) $display("FAIL clamp_err: err=%b required %b", bus.err_o, e);
        else n_pass++;
        collect(1'b0, 100);
    endtask

    task automatic test_h264_reset();
        bit e;
        t_lv[0] = 8'sd1; t_rn[0] = 9;
        t_lv[1] = 8'sd1; t_rn[1] = 0;
        start_block(5, 4, 16);
        send_pairs(2, 1'b0);
        #1;
        n_total++;
        if ({bus.err_o, bus.pair_ready_o} !== 2'b11)
            $display("FAIL mid_load: err=%b ready=%b required 1 1", bus.err_o, bus.pair_ready_o);
        else n_pass++;
        h264_reset = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if ({bus.pair_ready_o, bus.coeff_valid_o, bus.coeff_o, bus.coeff_idx_o,
             bus.blk_done_o, bus.busy_o, bus.err_o} !== '0)
            $display("FAIL h264_reset: busy=%b err=%b ready=%b required all 0", bus.busy_o, bus.err_o, bus.pair_ready_o);
        else n_pass++;
        h264_reset = 1'b0;
        t_lv[0] = 8'sd4; t_rn[0] = 0;
        model_push(1, 0, 16, e);
        start_block(1, 0, 16);
        send_pairs(1, 1'b0);
        collect(1'b0, 100);
    endtask

    task automatic test_async_rst();
        start_block(0, 0, 16);
        bus.coeff_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({bus.coeff_valid_o, bus.coeff_idx_o} !== {1'b1, 4'd3})
            $display("FAIL pre_rst: valid=%b idx=%0d required 1 3", bus.coeff_valid_o, bus.coeff_idx_o);
        else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_total++;
        if ({bus.pair_ready_o, bus.coeff_valid_o, bus.coeff_o, bus.coeff_idx_o,
             bus.blk_done_o, bus.busy_o, bus.err_o} !== '0)
            $display("FAIL async_rst: valid=%b idx=%0d busy=%b required all 0", bus.coeff_valid_o, bus.coeff_idx_o, bus.busy_o);
        else n_pass++;
        bus.coeff_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        test_recover(-8'sd3);
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_basic();
        test_stall();
        test_overflow();
        test_clamp();
        test_h264_reset();
        test_async_rst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
